// File: rtl/threshold_stream_reader.sv
// -----------------------------------------------------------------------------
// threshold_stream_reader
//
// Read-side sequencer for one per-block threshold ROM. A start pulse launches a
// run: the block reads consecutive ROM words starting at base_addr_i from an
// external 1-cycle-latency synchronous ROM. It unpacks each word LSB-field-first
// into THR_WIDTH-bit thresholds and hands them to the comparator stage one per
// valid/ready handshake. A run delivers exactly NUM_THR fields. That needs
// ceil(NUM_THR / (DATA_WIDTH/THR_WIDTH)) ROM reads. Unused high fields of the
// final word are never presented.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start_i      1-cycle start request, honoured only while idle
//   base_addr_i  first ROM word address, sampled when start is accepted
//   rom_en_o     ROM read enable (high only in the fetch cycle)
//   rom_addr_o   ROM read address, wraps modulo 2^ADDR_WIDTH
//   rom_data_i   ROM registered read data, valid the cycle after rom_en_o
//   thr_o        current threshold field
//   thr_idx_o    index of thr_o within the run, 0-based
//   thr_valid_o  thr_o / thr_idx_o valid
//   thr_ready_i  consumer accepts the field when valid & ready
//   thr_last_o   high with the field whose index is NUM_THR-1
//   busy_o       high whenever a run is in progress
//   done_o       1-cycle pulse after the last field is accepted
//
// DATA_WIDTH must be an integer multiple of THR_WIDTH.
// -----------------------------------------------------------------------------
module threshold_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int THR_WIDTH  = 8,
    parameter int NUM_THR    = 8,
    localparam int IDX_WIDTH = (NUM_THR > 1) ? $clog2(NUM_THR) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    output logic                  rom_en_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [THR_WIDTH-1:0]  thr_o,
    output logic [IDX_WIDTH-1:0]  thr_idx_o,
    output logic                  thr_valid_o,
    input  logic                  thr_ready_i,
    output logic                  thr_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    // Fields per ROM word and the pointer that walks them.
    localparam int FPW       = DATA_WIDTH / THR_WIDTH;
    localparam int PTR_WIDTH = (FPW > 1) ? $clog2(FPW) : 1;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_THR - 1);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(FPW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SERVE
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   base_q,      base_d;
    logic [ADDR_WIDTH-1:0]   word_cnt_q,  word_cnt_d;
    logic [PTR_WIDTH-1:0]    ptr_q,       ptr_d;
    logic [IDX_WIDTH-1:0]    idx_q,       idx_d;
    logic [DATA_WIDTH-1:0]   word_buf_q,  word_buf_d;

    // All outputs come straight from flops, so thr_ready_i never reaches
    // thr_valid_o or thr_o combinationally.
    logic                    rom_en_q,    rom_en_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q,  rom_addr_d;
    logic [THR_WIDTH-1:0]    thr_q,       thr_d;
    logic                    thr_valid_q, thr_valid_d;
    logic                    thr_last_q,  thr_last_d;
    logic                    done_q,      done_d;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    logic [PTR_WIDTH-1:0]    ptr_inc;
    logic [IDX_WIDTH-1:0]    idx_inc;
    logic [ADDR_WIDTH-1:0]   word_cnt_inc;
    logic [THR_WIDTH-1:0]    fields [FPW];

    assign ptr_inc      = ptr_q + PTR_WIDTH'(1);
    assign idx_inc      = idx_q + IDX_WIDTH'(1);
    assign word_cnt_inc = word_cnt_q + ADDR_WIDTH'(1);

    // Unpack the buffered word, field 0 in the least significant bits.
    for (genvar i = 0; i < FPW; i++) begin : g_fields
        assign fields[i] = word_buf_q[i*THR_WIDTH +: THR_WIDTH];
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement, so no
        // path leaves one unassigned and no latch can be inferred.
        state_d     = state_q;
        base_d      = base_q;
        word_cnt_d  = word_cnt_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        word_buf_d  = word_buf_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        thr_d       = thr_q;
        thr_valid_d = thr_valid_q;
        thr_last_d  = thr_last_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_FETCH;
                    base_d     = base_addr_i;
                    word_cnt_d = '0;
                    idx_d      = '0;
                    // The read is issued in the FETCH cycle, so the enable and
                    // address are loaded now.
                    rom_en_d   = 1'b1;
                    rom_addr_d = base_addr_i;
                end
            end

            S_FETCH: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                // ROM data is valid this cycle; field 0 comes straight from
                // the ROM bus so it can be presented in the next cycle.
                state_d     = S_SERVE;
                word_buf_d  = rom_data_i;
                ptr_d       = '0;
                thr_d       = rom_data_i[THR_WIDTH-1:0];
                thr_valid_d = 1'b1;
                thr_last_d  = (idx_q == LAST_IDX);
            end

            S_SERVE: begin
                if (thr_valid_q && thr_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        // Run complete. Index holds so thr_idx_o stays in range.
                        state_d     = S_IDLE;
                        thr_valid_d = 1'b0;
                        thr_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else if (ptr_q == LAST_PTR) begin
                        // Word exhausted: fetch the next one (address wraps).
                        state_d     = S_FETCH;
                        idx_d       = idx_inc;
                        word_cnt_d  = word_cnt_inc;
                        thr_valid_d = 1'b0;
                        thr_last_d  = 1'b0;
                        rom_en_d    = 1'b1;
                        rom_addr_d  = base_q + word_cnt_inc;
                    end else begin
                        // Next field of the same word, back to back.
                        idx_d      = idx_inc;
                        ptr_d      = ptr_inc;
                        thr_d      = fields[ptr_inc];
                        thr_last_d = (idx_inc == LAST_IDX);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its pre-edge value regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            word_cnt_q  <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            thr_q       <= '0;
            thr_valid_q <= 1'b0;
            thr_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            word_cnt_q  <= word_cnt_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            thr_q       <= thr_d;
            thr_valid_q <= thr_valid_d;
            thr_last_q  <= thr_last_d;
            done_q      <= done_d;
        end
    end

    // NOTE: the word buffer is pure datapath and is left without reset; it is
    // always written in CAPTURE before any field of it is presented.
    always_ff @(posedge clk) begin
        word_buf_q <= word_buf_d;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rom_en_o    = rom_en_q;
    assign rom_addr_o  = rom_addr_q;
    assign thr_o       = thr_q;
    assign thr_idx_o   = idx_q;
    assign thr_valid_o = thr_valid_q;
    assign thr_last_o  = thr_last_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

endmodule
